// File: rtl/halt_pkg.sv
// Shared encodings for the halt sequencer: exit causes, FSM states and the
// cause arbitration used when a trapping instruction retires.
package halt_pkg;

    typedef enum logic [1:0] {
        CAUSE_NONE    = 2'd0,
        CAUSE_BREAK   = 2'd1,
        CAUSE_UNKNOWN = 2'd2,
        CAUSE_TIMEOUT = 2'd3
    } cause_e;

    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_DRAIN  = 2'd1,
        ST_REPORT = 2'd2,
        ST_HALTED = 2'd3
    } state_e;

    // GPR index holding the program exit code.
    localparam int unsigned A0 = 10;

    // A failed decode outranks ebreak when both flag the same instruction.
    function automatic cause_e commit_cause(input logic is_unknown, input logic is_break);
        if (is_unknown)
            return CAUSE_UNKNOWN;
        else if (is_break)
            return CAUSE_BREAK;
        else
            return CAUSE_NONE;
    endfunction

endpackage

// File: rtl/halt_ctrl_wdog.sv
// No-commit watchdog: a saturating idle counter that pulses o_expire on the
// cycle it reaches WDOG_CYCLES-1 without a clear. WDOG_CYCLES == 0 disables it.
module halt_wdog #(
    parameter int unsigned WDOG_CYCLES = 100000
) (
    input  logic clk,
    input  logic reset,
    input  logic i_enable,
    input  logic i_clear,
    output logic o_expire
);

    localparam logic [31:0] LAST = (WDOG_CYCLES == 0) ? 32'd0 : 32'(WDOG_CYCLES - 1);

    logic [31:0] r_count;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values; blocking here would create order-dependent races.
    always_ff @(posedge clk) begin
        if (reset || i_clear || !i_enable)
            r_count <= '0;
        else if (r_count != '1)
            r_count <= r_count + 32'd1;
    end

    assign o_expire = (WDOG_CYCLES != 0) && i_enable && !i_clear && (r_count == LAST);

endmodule

// File: rtl/halt_ctrl.sv
// Trap/halt sequencer: arbitrates ebreak, unknown-instruction and watchdog
// halts, stalls fetch, drains memory, then hands out a latched exit record.
module halt_ctrl #(
    parameter int unsigned WDOG_CYCLES = 100000,
    parameter int unsigned DRAIN_MAX   = 64,
    parameter int unsigned XLEN        = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            commit_valid,
    input  logic [XLEN-1:0] commit_pc,
    input  logic            is_break_out,
    input  logic            is_unknown_instruction,
    input  logic [XLEN-1:0] a0_value,
    input  logic            mem_busy,
    input  logic            halt_ack,
    output logic            stall_o,
    output logic            halt_valid,
    output logic [1:0]      halt_cause,
    output logic [XLEN-1:0] halt_pc,
    output logic [XLEN-1:0] halt_code,
    output logic            good_trap,
    output logic            halted
);
    import halt_pkg::*;

    localparam logic [31:0] DRAIN_LAST = (DRAIN_MAX == 0) ? 32'd0 : 32'(DRAIN_MAX - 1);

    state_e          r_state;
    state_e          w_state_next;
    cause_e          r_cause;
    cause_e          w_cause_next;
    logic [XLEN-1:0] r_pc;
    logic [XLEN-1:0] w_pc_next;
    logic [XLEN-1:0] r_code;
    logic [XLEN-1:0] r_last_pc;
    logic [31:0]     r_drain_cnt;
    logic            r_good;

    logic            w_trap;
    logic            w_wdog_enable;
    logic            w_wdog_expire;
    logic            w_capture;
    logic            w_drain_inc;
    logic            w_enter_report;
    logic            w_drain_to;

    assign w_trap        = commit_valid && (is_unknown_instruction || is_break_out);
    assign w_wdog_enable = (r_state == ST_RUN);

    halt_wdog #(
        .WDOG_CYCLES(WDOG_CYCLES)
    ) u_wdog (
        .clk     (clk),
        .reset   (reset),
        .i_enable(w_wdog_enable),
        .i_clear (commit_valid),
        .o_expire(w_wdog_expire)
    );

    always_ff @(posedge clk) begin
        if (reset)
            r_state <= ST_RUN;
        else
            r_state <= w_state_next;
    end

    // NOTE: every signal driven here gets a default first; a path that leaves
    // one unassigned would infer a latch.
    always_comb begin
        w_state_next   = r_state;
        w_cause_next   = r_cause;
        w_pc_next      = r_pc;
        w_capture      = 1'b0;
        w_drain_inc    = 1'b0;
        w_enter_report = 1'b0;
        w_drain_to     = 1'b0;

        case (r_state)
            ST_RUN: begin
                // A commit also clears the watchdog, so a trap always beats a timeout.
                if (w_trap) begin
                    w_capture    = 1'b1;
                    w_cause_next = commit_cause(is_unknown_instruction, is_break_out);
                    w_pc_next    = commit_pc;
                    w_state_next = ST_DRAIN;
                end else if (w_wdog_expire) begin
                    w_capture    = 1'b1;
                    w_cause_next = CAUSE_TIMEOUT;
                    w_pc_next    = r_last_pc;
                    w_state_next = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (!mem_busy) begin
                    w_enter_report = 1'b1;
                    w_state_next   = ST_REPORT;
                end else if (r_drain_cnt == DRAIN_LAST) begin
                    w_enter_report = 1'b1;
                    w_drain_to     = 1'b1;
                    w_state_next   = ST_REPORT;
                end else begin
                    w_drain_inc = 1'b1;
                end
            end
            ST_REPORT: begin
                if (halt_ack)
                    w_state_next = ST_HALTED;
            end
            ST_HALTED: begin
                w_state_next = ST_HALTED;
            end
            default: begin
                w_state_next = ST_RUN;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_cause     <= CAUSE_NONE;
            r_pc        <= '0;
            r_code      <= '0;
            r_last_pc   <= '0;
            r_drain_cnt <= '0;
            r_good      <= 1'b0;
        end else begin
            if (commit_valid)
                r_last_pc <= commit_pc;
            if (w_capture) begin
                r_cause     <= w_cause_next;
                r_pc        <= w_pc_next;
                r_code      <= a0_value;
                r_drain_cnt <= '0;
            end
            if (w_drain_inc)
                r_drain_cnt <= r_drain_cnt + 32'd1;
            // A forced drain means memory may be inconsistent, so it never reports a good trap.
            if (w_enter_report)
                r_good <= (r_cause == CAUSE_BREAK) && (r_code == '0) && !w_drain_to;
        end
    end

    assign stall_o    = (r_state != ST_RUN);
    assign halt_valid = (r_state == ST_REPORT);
    assign halted     = (r_state == ST_HALTED);
    assign halt_cause = r_cause;
    assign halt_pc    = r_pc;
    assign halt_code  = r_code;
    assign good_trap  = r_good;

endmodule

// File: doc/halt_ctrl.md
Name: halt_ctrl

Overview:
- Trap/halt sequencer for the single-cycle core; sits between the commit stage and the simulation-exit logic.
- Arbitrates three halt sources: ebreak, unknown instruction and the no-commit watchdog.
- Stalls fetch, drains outstanding memory activity, then presents a latched exit record (cause, PC, a0 exit code) through a valid/ack handshake.
- Once acknowledged, holds the core halted until reset.

Parameters:
- WDOG_CYCLES, 100000: idle cycles without a commit before a timeout trap; 0 disables the watchdog.
- DRAIN_MAX, 64: maximum cycles spent waiting for mem_busy to clear before forcing the report.
- XLEN, 32: width of PC and exit-code data.

Ports:
- clk  in  1  core clock
- reset  in  1  synchronous, active-high reset
- commit_valid  in  1  an instruction retires this cycle
- commit_pc  in  XLEN  PC of the retiring instruction
- is_break_out  in  1  retiring instruction is ebreak; qualified by commit_valid
- is_unknown_instruction  in  1  retiring instruction failed decode; qualified by commit_valid
- a0_value  in  XLEN  current value of GPR x10
- mem_busy  in  1  LSU or memory transaction outstanding
- halt_ack  in  1  consumer accepts the exit record
- stall_o  out  1  freeze fetch and PC update
- halt_valid  out  1  exit record valid
- halt_cause  out  2  halt cause, encoded CAUSE_*
- halt_pc  out  XLEN  PC of the trapping instruction (last committed PC for a timeout)
- halt_code  out  XLEN  a0 captured at the trap
- good_trap  out  1  cause is BREAK, a0 == 0 and the drain completed
- halted  out  1  sticky halted state

Behaviour:
- States: RUN, DRAIN, REPORT, HALTED. Encoded 2 bits.
- Reset (synchronous, any state, including mid-DRAIN or mid-REPORT):
  - state returns to RUN; all counters clear.
  - All outputs go to 0: stall_o, halt_valid, halt_cause, halt_pc, halt_code, good_trap, halted.
  - The last-PC register clears to 0.
- RUN:
  - Trap event = commit_valid && (is_unknown_instruction || is_break_out).
  - Priority: UNKNOWN > BREAK > TIMEOUT. When is_unknown_instruction and is_break_out are both set, cause is UNKNOWN.
  - On an event, in the same edge: latch cause, halt_pc = commit_pc, halt_code = a0_value; then go to DRAIN.
  - The trapping instruction itself commits; stall_o rises the next cycle. stall_o is 1 in every state except RUN.
  - Watchdog counter: cleared on commit_valid, otherwise increments. When WDOG_CYCLES != 0 and the counter reaches WDOG_CYCLES-1 with no commit that cycle:
    - cause = TIMEOUT, halt_pc = last committed PC, halt_code = a0_value; go to DRAIN.
  - Trap event and watchdog expiry in the same cycle: the trap event wins, because a commit clears the watchdog.
  - The last committed PC register updates on every commit_valid.
- DRAIN:
  - Drain counter starts at 0.
  - mem_busy == 0: go to REPORT on the next edge. With mem_busy low on entry, DRAIN lasts exactly 1 cycle.
  - Otherwise the counter increments; when it reaches DRAIN_MAX-1, set drain_to flag and go to REPORT.
  - Trap inputs are ignored in DRAIN, REPORT and HALTED.
- REPORT:
  - halt_valid = 1; cause, pc, code and good_trap are held stable while halt_valid is high.
  - good_trap = (cause == BREAK) && (halt_code == 0) && !drain_to; registered when entering REPORT.
  - halt_ack while halt_valid is high: go to HALTED on that edge. halt_valid falls the next cycle.
  - halt_ack sampled in any other state is ignored.
- HALTED:
  - halted = 1, stall_o = 1; the record stays visible on halt_cause, halt_pc, halt_code and good_trap.
  - Remains until reset.
- Latency: trap commit to halt_valid = 2 cycles minimum (commit edge -> DRAIN -> REPORT).
- The watchdog counter is 32 bits and saturates; it does not wrap.

Decomposition:
- Shared package (halt_pkg):
  - CAUSE_NONE = 2'd0, CAUSE_BREAK = 2'd1, CAUSE_UNKNOWN = 2'd2, CAUSE_TIMEOUT = 2'd3.
  - State encoding ST_RUN, ST_DRAIN, ST_REPORT, ST_HALTED.
  - Register index A0 = 10.
- One natural sub-module, halt_wdog: watchdog counter with clear, enable and expiry pulse, parameterised by WDOG_CYCLES.
- Cause arbitration and the FSM stay in halt_ctrl.

Test Plan:
- Ebreak at pc=0x80000010, a0=0, mem_busy=0 -> halt_valid 2 cycles later, cause=1, halt_pc=0x80000010, code=0, good_trap=1; ack -> halted=1 and halt_valid=0 on the next cycle.
- Ebreak and unknown in the same commit, pc=0x80000020, a0=5 -> cause=2, halt_pc=0x80000020, good_trap=0.
- WDOG_CYCLES=8, last commit pc=0x80000100, then no commits -> after 8 idle cycles cause=3, halt_pc=0x80000100.
- Ebreak with mem_busy held high and DRAIN_MAX=4 -> REPORT entered after 4 DRAIN cycles, good_trap=0; a second run drops mem_busy after 2 cycles -> good_trap=1.
- Reset asserted during REPORT before ack -> next cycle all outputs 0, state RUN; a subsequent ebreak is handled normally.
- In HALTED, pulse is_unknown_instruction with commit_valid and toggle halt_ack -> record unchanged, halted and stall_o stay 1.
